mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter that shares one datapath resource (e.g. the data-memory port) among three requesters. It drives the 2-bit select of the shared 3-input operand/address mux and a one-hot grant back to the requesters. Ownership is held for a whole transaction, not a single beat. An optional watchdog revokes a grant that is held too long.

## Interface
- `TIMEOUT`, default 16: maximum number of grant cycles before forced revoke. Legal range 2..255. Used only with the watchdog compiled in.
- `clk`  in  1: single system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  3: level request per requester. Bit i is held high for the whole transaction.
- `grant`  out  3: registered one-hot grant, or 3'b000 when idle.
- `sel`  out  2: registered mux select. Equals the owner index (0..2) while granted, 2'd0 when idle. Value 2'd3 never occurs.
- `busy`  out  1: registered; 1 while any grant is active.
- `timeout_err`  out  1: registered one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- FSM with two states, IDLE and GRANT. Internal registers:
  - `owner[1:0]`: current owner.
  - `last[1:0]`: most recently granted index.
  - `cnt[7:0]`: grant-length counter.
  - `mask[2:0]`: revoked requesters.
- Reset values: state=IDLE, grant=000, sel=0, busy=0, timeout_err=0, last=2 (requester 0 wins first), cnt=0, mask=000.
- Behaviour in IDLE:
  - Form eligible = req & ~mask.
  - If eligible is nonzero, pick the first set bit scanning (last+1) mod 3, (last+2) mod 3, last.
  - On the next edge: state=GRANT, owner=last=winner, grant=onehot(winner), sel=winner, busy=1, cnt=0.
  - If eligible is zero, remain in IDLE.
- Behaviour in GRANT:
  - If req[owner]=0, go to IDLE on the next edge with grant=000, sel=0, busy=0.
  - Otherwise hold all outputs and increment cnt (saturating at 255).
- Requests from non-owners during GRANT are ignored until the return to IDLE. Grants never pass directly from one owner to another.
- Changing req bits never changes grant or sel mid-transaction.
- Mask handling:
  - `mask[i]` is cleared in any cycle where req[i]=0.
  - `mask[i]` is set only by the watchdog.

## Timing
- Grant latency: req rising in IDLE at edge t gives grant at edge t+1.
- Release: owner drops req before edge t; grant=000 after edge t. The earliest next grant is after edge t+1, so there is one mandatory idle cycle between owners.
- If a requester drops and re-raises req within one idle cycle, it competes normally under round-robin order.
- Asynchronous reset mid-transaction immediately forces all reset values. The first post-reset grant follows the rule for last=2.
- Simultaneous release and new requests: the release edge always goes to IDLE, and arbitration happens on the following edge.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- Defined:
  - In GRANT with req[owner]=1 and cnt==TIMEOUT-1, the next edge goes to IDLE with grant=000, sel=0, busy=0, timeout_err=1, and mask[owner]=1.
  - Grant is therefore high for exactly TIMEOUT cycles.
  - timeout_err returns to 0 on the following edge.
  - The revoked requester is ineligible until it deasserts req for at least one cycle.
- Undefined:
  - No counter logic, no mask.
  - timeout_err is tied to 0.
  - A grant is held for as long as req[owner] stays high.

## Test plan
- Reset: assert rst asynchronously between edges -> grant=000, sel=0, busy=0, timeout_err=0 immediately. The first request with req=111 is granted to 0.
- Single owner: req=001 before edge 1, dropped before edge 5 -> grant=001/sel=0/busy=1 after edges 1..4, grant=000 after edge 5.
- Round robin: req=111 held, with each owner dropping its bit for exactly one cycle after holding for 2 cycles -> grant sequence 0,1,2,0,1, each separated by one idle cycle, sel tracking owner.
- Priority rotation: after owner 0 releases, apply req=101 -> grant=100 (sel=2), not 001.
- Watchdog (ARB_TIMEOUT_EN, TIMEOUT=4): req=100 held high, req=001 raised later -> grant=100 for exactly 4 cycles, then one cycle with timeout_err=1 and grant=000, then grant=001. Requester 2 is not re-granted until it drops req once.
- Mid-grant reset: with grant=010 active, pulse rst -> outputs clear immediately. After release of reset with req=010 still high, grant=010 follows one edge later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for a shared datapath port with transaction-long ownership.
// Define ARB_TIMEOUT_EN to compile in the grant-length watchdog (uses TIMEOUT).
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q,  last_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic       busy_q,  busy_d;
    logic       terr_q,  terr_d;

    logic [2:0] eligible;
    logic       found;
    logic [1:0] winner;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q,  cnt_d;
    logic [2:0] mask_q, mask_d;

    assign eligible = req & ~mask_q;
`else
    assign eligible = req;
`endif

    // Scan (last+1), (last+2), last modulo 3; first eligible bit wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= 3; k++) begin
            int unsigned idx;
            idx = (32'(last_q) + k) % 3;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = 2'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        terr_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        mask_d  = mask_q & req;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    owner_d = winner;
                    last_d  = winner;
                    grant_d = 3'b001 << winner;
                    sel_d   = winner;
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d         = IDLE;
                    grant_d         = '0;
                    sel_d           = '0;
                    busy_d          = 1'b0;
                    terr_d          = 1'b1;
                    mask_d[owner_q] = 1'b1;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= 2'd2;
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            mask_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
        end
    end
`endif

    assign grant       = grant_q;
    assign sel         = sel_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed literal scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = '0;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .sel         (sel),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner is -1 when idle.
    int       m_owner, m_last, m_cnt;
    bit [2:0] m_mask, m_newmask;
    bit       m_terr, m_found;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_last  = 2;
            m_cnt   = 0;
            m_mask  = '0;
            m_terr  = 1'b0;
        end else begin
            m_terr    = 1'b0;
            m_newmask = m_mask & req;
            if (m_owner < 0) begin
                m_found = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_last + k) % 3;
                    if (!m_found && req[c] && !m_mask[c]) begin
                        m_found = 1'b1;
                        m_owner = c;
                        m_last  = c;
                        m_cnt   = 0;
                    end
                end
            end else if (!req[m_owner]) begin
                m_owner = -1;
            end else begin
`ifdef ARB_TIMEOUT_EN
                if (m_cnt == TO - 1) begin
                    m_newmask[m_owner] = 1'b1;
                    m_terr  = 1'b1;
                    m_owner = -1;
                end else if (m_cnt < 255) begin
                    m_cnt++;
                end
`endif
            end
            m_mask = m_newmask;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [2:0] eg;
            logic [1:0] es;
            eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
            es = (m_owner < 0) ? 2'd0 : 2'(m_owner);
            chk("model_grant", 32'(grant), 32'(eg));
            chk("model_sel", 32'(sel), 32'(es));
            chk("model_busy", 32'(busy), 32'(m_owner >= 0));
            chk("model_terr", 32'(timeout_err), 32'(m_terr));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_out(input string name, input logic [2:0] g, input logic [1:0] s,
                           input logic b, input logic t);
        chk({name, "_grant"}, 32'(grant), 32'(g));
        chk({name, "_sel"}, 32'(sel), 32'(s));
        chk({name, "_busy"}, 32'(busy), 32'(b));
        chk({name, "_terr"}, 32'(timeout_err), 32'(t));
    endtask

    initial begin
        repeat (2) cyc();
        chk_out("reset", 3'b000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // First grant after reset with all requesting goes to 0.
        req = 3'b111;
        cyc();
        chk_out("first_after_reset", 3'b001, 2'd0, 1'b1, 1'b0);
        req = 3'b000;
        cyc();
        chk_out("first_release", 3'b000, 2'd0, 1'b0, 1'b0);
        cyc();

        // Single owner held for four edges.
        req = 3'b001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_out("single_hold", 3'b001, 2'd0, 1'b1, 1'b0);
        end
        req = 3'b000;
        cyc();
        chk_out("single_release", 3'b000, 2'd0, 1'b0, 1'b0);
        cyc();

        // Last owner was 0, so 101 must rotate to 2.
        req = 3'b101;
        cyc();
        chk_out("rotation", 3'b100, 2'd2, 1'b1, 1'b0);
        req = 3'b000;
        repeat (2) cyc();

        // Round robin with all requesting; last=2 so order is 0,1,2,0,1.
        req = 3'b111;
        for (int k = 0; k < 5; k++) begin
            int o;
            o = k % 3;
            cyc();
            chk_out("rr_grant_a", 3'(1 << o), 2'(o), 1'b1, 1'b0);
            cyc();
            chk_out("rr_grant_b", 3'(1 << o), 2'(o), 1'b1, 1'b0);
            req = 3'b111 & ~3'(1 << o);
            cyc();
            chk_out("rr_idle", 3'b000, 2'd0, 1'b0, 1'b0);
            req = 3'b111;
        end
        req = 3'b000;
        repeat (2) cyc();

`ifdef ARB_TIMEOUT_EN
        // Watchdog revokes 2 after TO cycles, hands over to 0, keeps 2 masked.
        req = 3'b100;
        for (int i = 0; i < TO; i++) begin
            cyc();
            chk_out("wd_hold", 3'b100, 2'd2, 1'b1, 1'b0);
            req = 3'b101;
        end
        cyc();
        chk_out("wd_revoke", 3'b000, 2'd0, 1'b0, 1'b1);
        cyc();
        chk_out("wd_next", 3'b001, 2'd0, 1'b1, 1'b0);
        req = 3'b100;
        cyc();
        chk_out("wd_release0", 3'b000, 2'd0, 1'b0, 1'b0);
        cyc();
        chk_out("wd_masked", 3'b000, 2'd0, 1'b0, 1'b0);
        req = 3'b000;
        cyc();
        chk_out("wd_drop", 3'b000, 2'd0, 1'b0, 1'b0);
        req = 3'b100;
        cyc();
        chk_out("wd_regrant", 3'b100, 2'd2, 1'b1, 1'b0);
        req = 3'b000;
        repeat (2) cyc();
`endif

        // Mid-grant asynchronous reset.
        req = 3'b010;
        cyc();
        chk_out("pre_reset_grant", 3'b010, 2'd1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 chk_out("async_reset", 3'b000, 2'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        cyc();
        chk_out("post_reset_grant", 3'b010, 2'd1, 1'b1, 1'b0);
        req = 3'b000;
        repeat (2) cyc();

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 4000; n++) begin
            logic [2:0] r;
            r = req;
            for (int i = 0; i < 3; i++) begin
                if (m_owner == i)
                    r[i] = ($urandom_range(0, 11) != 0);
                else
                    r[i] = ($urandom_range(0, 2) != 0) ? r[i] : ~r[i];
            end
            req = r;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 chk_out("rand_async_reset", 3'b000, 2'd0, 1'b0, 1'b0);
                #1 rst = 1'b0;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
